// File: rtl/manta_bus_scheduler_if.sv
// Purpose : bundles the receiver, core-chain and transmitter signals of the Manta bus scheduler.
// Latency : none, wires only.
// Backpressure: rx_valid_i/rx_ready_o on the request side, tx_valid_o/tx_ready_i on the read-data side.
//
// Modports:
//   master - the scheduler. It consumes rx_* and the chain end, and drives bus_*_o, tx_*_o and status.
//   slave  - the surroundings. These are the receiver, the chain, the transmitter and status observers.
// Signal names keep the scheduler-relative _i/_o suffixes so both sides read against one table.
interface manta_bus_scheduler_if;
    logic [15:0] rx_addr_i;
    logic [15:0] rx_data_i;
    logic        rx_rw_i;
    logic        rx_valid_i;
    logic        rx_ready_o;

    logic [15:0] bus_addr_o;
    logic [15:0] bus_data_o;
    logic        bus_rw_o;
    logic        bus_valid_o;

    logic [15:0] bus_data_i;
    logic        bus_rw_i;
    logic        bus_valid_i;

    logic [15:0] tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;

    logic        timeout_o;
    logic [7:0]  stale_cnt_o;
    logic        busy_o;

    modport master (
        input  rx_addr_i, rx_data_i, rx_rw_i, rx_valid_i,
        output rx_ready_o,
        output bus_addr_o, bus_data_o, bus_rw_o, bus_valid_o,
        input  bus_data_i, bus_rw_i, bus_valid_i,
        output tx_data_o, tx_valid_o,
        input  tx_ready_i,
        output timeout_o, stale_cnt_o, busy_o
    );

    modport slave (
        output rx_addr_i, rx_data_i, rx_rw_i, rx_valid_i,
        input  rx_ready_o,
        input  bus_addr_o, bus_data_o, bus_rw_o, bus_valid_o,
        output bus_data_i, bus_rw_i, bus_valid_i,
        input  tx_data_o, tx_valid_o,
        output tx_ready_i,
        input  timeout_o, stale_cnt_o, busy_o
    );
endinterface

// File: rtl/manta_bus_scheduler.sv
// Purpose : sequences host requests onto the Manta core chain and returns read data to the host.
// Latency : the bus strobe follows acceptance by 1 cycle, and tx_valid_o follows the chain read response by 1 cycle.
// Backpressure: writes are taken at full rate. A read holds rx_ready_o low until tx_ready_i takes the read data.
//
// Ports: clk and rst_n (asynchronous, active-low) are plain ports. All other signals are in
// manta_bus_scheduler_if.master. This covers the request side (rx_*), the chain input (bus_*_o),
// the chain end (bus_*_i), the read data (tx_*), and the status outputs timeout_o, stale_cnt_o and busy_o.
// Build option: define MANTA_SCHED_TIMEOUT_EN to add the read timeout. This uses TIMEOUT and TIMEOUT_DATA.
// Without the macro a read waits for its response indefinitely.
module manta_bus_scheduler #(
    parameter int unsigned TIMEOUT      = 64,
    parameter logic [15:0] TIMEOUT_DATA = 16'hDEAD
) (
    input  logic                      clk,
    input  logic                      rst_n,
    manta_bus_scheduler_if.master     bus_if
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] bus_addr_q, bus_addr_d;
    logic [15:0] bus_data_q, bus_data_d;
    logic        bus_rw_q, bus_rw_d;
    logic        bus_valid_q, bus_valid_d;
    logic [15:0] tx_data_q, tx_data_d;
    logic [7:0]  stale_q, stale_d;

    logic accept;
    logic rd_resp;
    logic expire;

    assign accept  = bus_if.rx_valid_i & (state_q == ST_IDLE);
    // Write echoes at the chain end carry no information for the host and are ignored.
    assign rd_resp = bus_if.bus_valid_i & ~bus_if.bus_rw_i;

`ifdef MANTA_SCHED_TIMEOUT_EN
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    logic [15:0] cnt_q, cnt_d;

    // A response in the expiry cycle takes priority, so the timeout is suppressed then.
    assign expire = (state_q == ST_WAIT) & (cnt_q == CNT_LAST) & ~rd_resp;

    always_comb begin
        cnt_d = cnt_q;
        if (accept & ~bus_if.rx_rw_i) begin
            cnt_d = '0;
        end else if (state_q == ST_WAIT) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_params;

    assign expire        = 1'b0;
    assign unused_params = ^{TIMEOUT, TIMEOUT_DATA};
`endif

    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        bus_valid_d = accept;
        bus_addr_d  = bus_addr_q;
        bus_data_d  = bus_data_q;
        bus_rw_d    = bus_rw_q;
        stale_d     = stale_q;

        if (accept) begin
            bus_addr_d = bus_if.rx_addr_i;
            bus_data_d = bus_if.rx_data_i;
            bus_rw_d   = bus_if.rx_rw_i;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept & ~bus_if.rx_rw_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (rd_resp) begin
                    tx_data_d = bus_if.bus_data_i;
                    state_d   = ST_RESP;
                end else if (expire) begin
                    tx_data_d = TIMEOUT_DATA;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus_if.tx_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A read response that arrives with no read outstanding is late or unsolicited.
        if (rd_resp && (state_q != ST_WAIT) && (stale_q != 8'hFF)) begin
            stale_d = stale_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bus_addr_q  <= '0;
            bus_data_q  <= '0;
            bus_rw_q    <= 1'b0;
            bus_valid_q <= 1'b0;
            tx_data_q   <= '0;
            stale_q     <= '0;
        end else begin
            state_q     <= state_d;
            bus_addr_q  <= bus_addr_d;
            bus_data_q  <= bus_data_d;
            bus_rw_q    <= bus_rw_d;
            bus_valid_q <= bus_valid_d;
            tx_data_q   <= tx_data_d;
            stale_q     <= stale_d;
        end
    end

    assign bus_if.rx_ready_o  = (state_q == ST_IDLE);
    assign bus_if.busy_o      = (state_q != ST_IDLE);
    assign bus_if.tx_valid_o  = (state_q == ST_RESP);
    assign bus_if.tx_data_o   = tx_data_q;
    assign bus_if.bus_addr_o  = bus_addr_q;
    assign bus_if.bus_data_o  = bus_data_q;
    assign bus_if.bus_rw_o    = bus_rw_q;
    assign bus_if.bus_valid_o = bus_valid_q;
    assign bus_if.timeout_o   = expire;
    assign bus_if.stale_cnt_o = stale_q;

endmodule

// File: tb/tb_manta_bus_scheduler.sv
// Directed bench for manta_bus_scheduler with TIMEOUT = 8.
// Inputs are driven and outputs are sampled 1 time unit after each rising edge.
module tb_manta_bus_scheduler;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    manta_bus_scheduler_if ifc ();

    manta_bus_scheduler #(
        .TIMEOUT      (8),
        .TIMEOUT_DATA (16'hDEAD)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic vld, input logic rw, input logic [15:0] addr, input logic [15:0] data);
        ifc.rx_valid_i = vld;
        ifc.rx_rw_i    = rw;
        ifc.rx_addr_i  = addr;
        ifc.rx_data_i  = data;
    endtask

    task automatic set_chain(input logic vld, input logic rw, input logic [15:0] data);
        ifc.bus_valid_i = vld;
        ifc.bus_rw_i    = rw;
        ifc.bus_data_i  = data;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b1;
        set_req(1'b0, 1'b0, 16'h0, 16'h0);
        set_chain(1'b0, 1'b0, 16'h0);
        ifc.tx_ready_i = 1'b0;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst_bus_valid", ifc.bus_valid_o, 0);
        check("rst_tx_valid",  ifc.tx_valid_o,  0);
        check("rst_timeout",   ifc.timeout_o,   0);
        check("rst_busy",      ifc.busy_o,      0);
        check("rst_rx_ready",  ifc.rx_ready_o,  1);
        check("rst_bus_addr",  ifc.bus_addr_o,  0);
        check("rst_bus_data",  ifc.bus_data_o,  0);
        check("rst_bus_rw",    ifc.bus_rw_o,    0);
        check("rst_tx_data",   ifc.tx_data_o,   0);
        check("rst_stale",     ifc.stale_cnt_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();

        // Back-to-back writes
        set_req(1'b1, 1'b1, 16'h0010, 16'h1111);
        check("wr_rdy0", ifc.rx_ready_o, 1);
        step();
        check("wr0_vld",  ifc.bus_valid_o, 1);
        check("wr0_addr", ifc.bus_addr_o, 16'h0010);
        check("wr0_data", ifc.bus_data_o, 16'h1111);
        check("wr0_rw",   ifc.bus_rw_o, 1);
        check("wr_rdy1",  ifc.rx_ready_o, 1);
        set_req(1'b1, 1'b1, 16'h0011, 16'h2222);
        step();
        check("wr1_vld",  ifc.bus_valid_o, 1);
        check("wr1_addr", ifc.bus_addr_o, 16'h0011);
        check("wr1_data", ifc.bus_data_o, 16'h2222);
        check("wr_rdy2",  ifc.rx_ready_o, 1);
        set_req(1'b1, 1'b1, 16'h0012, 16'h3333);
        step();
        check("wr2_vld",  ifc.bus_valid_o, 1);
        check("wr2_addr", ifc.bus_addr_o, 16'h0012);
        check("wr2_data", ifc.bus_data_o, 16'h3333);
        set_req(1'b0, 1'b0, 16'h0099, 16'h9999);
        step();
        check("wr_end_vld",  ifc.bus_valid_o, 0);
        check("wr_hold_adr", ifc.bus_addr_o, 16'h0012);
        check("wr_hold_dat", ifc.bus_data_o, 16'h3333);
        check("wr_busy",     ifc.busy_o, 0);

        // Basic read; response 4 cycles after the strobe, write echo ignored
        set_req(1'b1, 1'b0, 16'h0020, 16'h0);
        step();
        set_req(1'b0, 1'b0, 16'h0, 16'h0);
        check("rd_vld",   ifc.bus_valid_o, 1);
        check("rd_addr",  ifc.bus_addr_o, 16'h0020);
        check("rd_rw",    ifc.bus_rw_o, 0);
        check("rd_busy",  ifc.busy_o, 1);
        check("rd_rdy",   ifc.rx_ready_o, 0);
        step();
        check("rd_strobe_once", ifc.bus_valid_o, 0);
        set_chain(1'b1, 1'b1, 16'h1234);
        step();
        set_chain(1'b0, 1'b0, 16'h0);
        step();
        check("echo_no_resp", ifc.tx_valid_o, 0);
        check("echo_stale",   ifc.stale_cnt_o, 0);
        step();
        set_chain(1'b1, 1'b0, 16'hBEEF);
        check("rd_wait_txv", ifc.tx_valid_o, 0);
        step();
        set_chain(1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            check("rd_txv",  ifc.tx_valid_o, 1);
            check("rd_txd",  ifc.tx_data_o, 16'hBEEF);
            check("rd_hold_rdy", ifc.rx_ready_o, 0);
            step();
        end
        ifc.tx_ready_i = 1'b1;
        check("rd_txv_hs", ifc.tx_valid_o, 1);
        step();
        ifc.tx_ready_i = 1'b0;
        check("rd_done_rdy", ifc.rx_ready_o, 1);
        check("rd_done_txv", ifc.tx_valid_o, 0);
        check("rd_stale",    ifc.stale_cnt_o, 0);

`ifdef MANTA_SCHED_TIMEOUT_EN
        // Read timeout: accepted in cycle N, expiry in N+8
        set_req(1'b1, 1'b0, 16'h0030, 16'h0);
        step();
        set_req(1'b0, 1'b0, 16'h0, 16'h0);
        repeat (6) step();
        check("to_n7", ifc.timeout_o, 0);
        step();
        check("to_n8", ifc.timeout_o, 1);
        check("to_n8_txv", ifc.tx_valid_o, 0);
        step();
        check("to_n9_pulse", ifc.timeout_o, 0);
        check("to_txv", ifc.tx_valid_o, 1);
        check("to_txd", ifc.tx_data_o, 16'hDEAD);
        ifc.tx_ready_i = 1'b1;
        step();
        ifc.tx_ready_i = 1'b0;
`endif
        // Late or unsolicited response in IDLE counts as stale
        set_chain(1'b1, 1'b0, 16'h5555);
        step();
        set_chain(1'b0, 1'b0, 16'h0);
        check("late_stale", ifc.stale_cnt_o, 1);
        check("late_txv",   ifc.tx_valid_o, 0);

        // Response arriving exactly on the timeout cycle wins
        set_req(1'b1, 1'b0, 16'h0040, 16'h0);
        step();
        set_req(1'b0, 1'b0, 16'h0, 16'h0);
        repeat (7) step();
        set_chain(1'b1, 1'b0, 16'h7777);
        check("race_no_to", ifc.timeout_o, 0);
        step();
        set_chain(1'b0, 1'b0, 16'h0);
        check("race_txv",   ifc.tx_valid_o, 1);
        check("race_txd",   ifc.tx_data_o, 16'h7777);
        check("race_to",    ifc.timeout_o, 0);
        check("race_stale", ifc.stale_cnt_o, 1);
        ifc.tx_ready_i = 1'b1;
        step();
        ifc.tx_ready_i = 1'b0;

        // Asynchronous reset while a read is outstanding
        set_req(1'b1, 1'b0, 16'h0050, 16'h0);
        step();
        set_req(1'b0, 1'b0, 16'h0, 16'h0);
        check("mid_pre_vld", ifc.bus_valid_o, 1);
        #3 rst_n = 1'b0;
        #1;
        check("mid_bus_vld",  ifc.bus_valid_o, 0);
        check("mid_bus_addr", ifc.bus_addr_o, 0);
        check("mid_busy",     ifc.busy_o, 0);
        check("mid_rdy",      ifc.rx_ready_o, 1);
        check("mid_txd",      ifc.tx_data_o, 0);
        check("mid_stale",    ifc.stale_cnt_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        set_chain(1'b1, 1'b0, 16'hABCD);
        step();
        set_chain(1'b0, 1'b0, 16'h0);
        check("old_resp_stale", ifc.stale_cnt_o, 1);
        check("old_resp_txv",   ifc.tx_valid_o, 0);
        check("old_resp_busy",  ifc.busy_o, 0);

        // Stale counter saturation: 300 unsolicited responses
        set_chain(1'b1, 1'b0, 16'h0101);
        repeat (253) step();
        check("sat_254", ifc.stale_cnt_o, 254);
        repeat (47) step();
        set_chain(1'b0, 1'b0, 16'h0);
        check("sat_255", ifc.stale_cnt_o, 255);
        step();
        check("sat_hold", ifc.stale_cnt_o, 255);
        check("sat_rdy",  ifc.rx_ready_o, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
